// File: rtl/ds3231_poll_ctrl_if.sv
// ---------------------------------------------------------------------------
// ds3231_poll_ctrl_if
// Handshake between the DS3231 poll controller and the byte-read I2C engine.
//   i2c_start      ctrl -> engine  held high for one byte-read transaction
//   i2c_deviceaddw ctrl -> engine  write address {DEV_ADDR,0}
//   i2c_deviceaddr ctrl -> engine  read address  {DEV_ADDR,1}
//   i2c_rdaddr     ctrl -> engine  RTC register index being read
//   i2c_over       engine -> ctrl  transaction done (level while start high)
//   i2c_rddat      engine -> ctrl  returned byte, valid while i2c_over=1
// ---------------------------------------------------------------------------
interface ds3231_poll_ctrl_if;
    logic       i2c_start;
    logic [7:0] i2c_deviceaddw;
    logic [7:0] i2c_deviceaddr;
    logic [7:0] i2c_rdaddr;
    logic       i2c_over;
    logic [7:0] i2c_rddat;

    modport master (
        output i2c_start,
        output i2c_deviceaddw,
        output i2c_deviceaddr,
        output i2c_rdaddr,
        input  i2c_over,
        input  i2c_rddat
    );

    modport slave (
        input  i2c_start,
        input  i2c_deviceaddw,
        input  i2c_deviceaddr,
        input  i2c_rdaddr,
        output i2c_over,
        output i2c_rddat
    );
endinterface

// File: rtl/ds3231_poll_ctrl.sv
// ---------------------------------------------------------------------------
// ds3231_poll_ctrl
// Polls DS3231 RTC registers 0x00..0x06 through a byte-read I2C engine and
// commits them atomically as one time/date frame.
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   auto_en      enables periodic polling every POLL_DIV cycles
//   trig         single-cycle request for one poll frame
//   bus          master side of the I2C byte-read handshake
//   sec..year    committed RTC registers (raw BCD)
//   frame_valid  one-cycle pulse when a new frame is committed
//   busy         controller not idle
//   err          sticky byte-read timeout flag, cleared by a good commit
// ---------------------------------------------------------------------------
module ds3231_poll_ctrl #(
    parameter logic [6:0]  DEV_ADDR = 7'h68,
    parameter int unsigned POLL_DIV = 1000000,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               auto_en,
    input  logic               trig,
    ds3231_poll_ctrl_if.master bus,
    output logic [7:0]         sec,
    output logic [7:0]         min,
    output logic [7:0]         hour,
    output logic [7:0]         day,
    output logic [7:0]         date,
    output logic [7:0]         month,
    output logic [7:0]         year,
    output logic               frame_valid,
    output logic               busy,
    output logic               err
);

    localparam int unsigned   PW       = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned   WW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PMAX     = PW'(POLL_DIV - 1);
    localparam logic [WW-1:0] WMAX     = WW'(TIMEOUT - 1);
    localparam logic [2:0]    LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q;
    logic          tick;
    logic          pend_q, pend_d;
    logic [2:0]    idx_q, idx_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          gap_q, gap_d;
    logic [7:0]    shadow_q [7];
    logic [7:0]    shadow_d [7];
    logic [7:0]    regs_q [7];
    logic [7:0]    regs_d [7];
    logic          start_q, start_d;
    logic [7:0]    rdaddr_q, rdaddr_d;
    logic          fv_q, fv_d;
    logic          err_q, err_d;
    logic          req_in;

    // Free-running period counter; frozen at zero while auto polling is off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!auto_en) begin
            cnt_q <= '0;
        end else if (cnt_q == PMAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick   = auto_en && (cnt_q == PMAX);
    assign req_in = trig || tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            idx_q    <= '0;
            wd_q     <= '0;
            gap_q    <= 1'b0;
            start_q  <= 1'b0;
            rdaddr_q <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) begin
                shadow_q[i] <= '0;
                regs_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            start_q  <= start_d;
            rdaddr_q <= rdaddr_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            regs_q   <= regs_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        // Requests arriving while busy fold into the single pending flag.
        pend_d   = pend_q || req_in;
        idx_d    = idx_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        regs_d   = regs_q;
        fv_d     = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q || req_in) begin
                    state_d = S_ISSUE;
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    wd_d    = '0;
                end
            end
            S_ISSUE: begin
                wd_d = wd_q + 1'b1;
                // A completed byte wins over a watchdog expiring in the same cycle.
                if (bus.i2c_over) begin
                    for (int unsigned i = 0; i < 7; i++) begin
                        if (idx_q == 3'(i)) begin
                            shadow_d[i] = bus.i2c_rddat;
                        end
                    end
                    state_d = S_GAP;
                    gap_d   = 1'b0;
                end else if (wd_q == WMAX) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_ISSUE;
                    idx_d   = idx_q + 1'b1;
                    wd_d    = '0;
                end
            end
            S_COMMIT: begin
                regs_d  = shadow_q;
                fv_d    = 1'b1;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                err_d = 1'b1;
                for (int unsigned i = 0; i < 7; i++) begin
                    shadow_d[i] = '0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so start is high exactly in ISSUE and
        // the register index only moves on ISSUE entry.
        start_d  = (state_d == S_ISSUE);
        rdaddr_d = {5'b0, idx_d};
    end

    assign bus.i2c_start      = start_q;
    assign bus.i2c_rdaddr     = rdaddr_q;
    assign bus.i2c_deviceaddw = {DEV_ADDR, 1'b0};
    assign bus.i2c_deviceaddr = {DEV_ADDR, 1'b1};

    assign sec         = regs_q[0];
    assign min         = regs_q[1];
    assign hour        = regs_q[2];
    assign day         = regs_q[3];
    assign date        = regs_q[4];
    assign month       = regs_q[5];
    assign year        = regs_q[6];
    assign frame_valid = fv_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_ds3231_poll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ds3231_poll_ctrl
// Self-checking bench for ds3231_poll_ctrl: a behavioural byte-read engine
// with per-register latency, a negedge bus monitor, and scenario tasks whose
// expectations come from frame-level arithmetic on the engine settings.
// ---------------------------------------------------------------------------
module tb_ds3231_poll_ctrl;

    localparam int PDIV = 200;
    localparam int TOUT = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       auto_en;
    logic       trig;
    logic [7:0] sec, min, hour, day, date, month, year;
    logic       frame_valid, busy, err;

    ds3231_poll_ctrl_if bus ();

    ds3231_poll_ctrl #(
        .DEV_ADDR (7'h68),
        .POLL_DIV (PDIV),
        .TIMEOUT  (TOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .auto_en     (auto_en),
        .trig        (trig),
        .bus         (bus),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day         (day),
        .date        (date),
        .month       (month),
        .year        (year),
        .frame_valid (frame_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- engine model ----------------
    int         lat [8];
    logic [7:0] dat [8];
    int         hang_idx = -1;
    int         eng_cnt  = 0;

    always @(posedge clk) begin
        if (!bus.i2c_start) begin
            eng_cnt      <= 0;
            bus.i2c_over <= 1'b0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (int'(bus.i2c_rdaddr) != hang_idx && eng_cnt == lat[bus.i2c_rdaddr[2:0]] - 1) begin
                bus.i2c_over  <= 1'b1;
                bus.i2c_rddat <= dat[bus.i2c_rdaddr[2:0]];
            end
        end
    end

    // ---------------- bus monitor ----------------
    int         cyc = 0;
    logic       prev_start = 1'b0;
    int         rise_cyc = 0;
    logic [7:0] held_rd = '0;
    int         q_rd [$];
    int         q_fstart [$];
    int         q_fv [$];
    int         dur [8];
    int         fv_cnt = 0;
    int         stab_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.i2c_start && !prev_start) begin
            q_rd.push_back(int'(bus.i2c_rdaddr));
            rise_cyc = cyc;
            held_rd  = bus.i2c_rdaddr;
            if (bus.i2c_rdaddr == 8'd0) q_fstart.push_back(cyc);
        end else if (bus.i2c_start && bus.i2c_rdaddr != held_rd) begin
            stab_err++;
        end
        if (!bus.i2c_start && prev_start) dur[held_rd[2:0]] = cyc - rise_cyc;
        if (frame_valid) begin
            fv_cnt++;
            q_fv.push_back(cyc);
        end
        prev_start = bus.i2c_start;
    end

    // ---------------- helpers (stimulus / model only) ----------------
    logic [55:0] exp_regs = '0;

    function automatic logic [55:0] dut_regs();
        return {year, month, date, day, hour, min, sec};
    endfunction

    function automatic logic [55:0] pack_dat();
        logic [55:0] p;
        for (int i = 0; i < 7; i++) p[i*8 +: 8] = dat[i];
        return p;
    endfunction

    // Expected cycles from ISSUE entry to frame_valid for the current latencies.
    function automatic int frame_len();
        int s = 1;
        for (int i = 0; i < 7; i++) s += lat[i] + 1 + 2;
        return s;
    endfunction

    function automatic int seq_ok(input int first, input int count);
        if (q_rd.size() != count) return 0;
        for (int i = 0; i < count; i++) if (q_rd[i] != first + (i % 7)) return 0;
        return 1;
    endfunction

    task automatic clear_logs();
        q_rd.delete();
        q_fstart.delete();
        q_fv.delete();
        for (int i = 0; i < 8; i++) dur[i] = 0;
    endtask

    task automatic pulse_trig(output int tcyc);
        @(negedge clk);
        trig = 1'b1;
        tcyc = cyc;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        checks++;
        if (quiet < 3) begin
            errors++;
            $display("FAIL idle_wait: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic set_engine(input int l);
        for (int i = 0; i < 8; i++) begin
            lat[i] = l;
            dat[i] = 8'($urandom_range(255, 0));
        end
        hang_idx = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        auto_en = 1'b0;
        trig = 1'b0;
        set_engine(2);
        repeat (3) @(negedge clk);
        checks++; if (bus.i2c_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b need 0", bus.i2c_start); end
        checks++; if (bus.i2c_rdaddr !== 8'h00) begin errors++; $display("FAIL rst_rdaddr: got %0h need 00", bus.i2c_rdaddr); end
        checks++; if (dut_regs() !== 56'h0) begin errors++; $display("FAIL rst_regs: got %0h need 0", dut_regs()); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_fv: got %0b need 0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b need 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b need 0", err); end
        checks++; if (bus.i2c_deviceaddw !== 8'hD0) begin errors++; $display("FAIL rst_addw: got %0h need d0", bus.i2c_deviceaddw); end
        checks++; if (bus.i2c_deviceaddr !== 8'hD1) begin errors++; $display("FAIL rst_addr: got %0h need d1", bus.i2c_deviceaddr); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst: busy got %0b need 0", busy); end
    endtask

    task automatic test_frame();
        int tc, fv0;
        logic [7:0] fixed [7] = '{8'h30, 8'h59, 8'h23, 8'h04, 8'h15, 8'h08, 8'h24};
        for (int i = 0; i < 7; i++) begin
            lat[i] = 10;
            dat[i] = fixed[i];
        end
        hang_idx = -1;
        clear_logs();
        fv0 = fv_cnt;
        stab_err = 0;
        pulse_trig(tc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %0b need 1", busy); end
        wait_idle(2000);
        exp_regs = pack_dat();
        checks++; if (seq_ok(0, 7) != 1) begin errors++; $display("FAIL frame_rdseq: got %0d addrs, need 0..6", q_rd.size()); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL frame_fvcount: got %0d need 1", fv_cnt - fv0); end
        checks++; if (q_fstart.size() < 1 || q_fstart[0] !== tc + 1) begin errors++; $display("FAIL frame_start_lat: got %0d starts, need start at cycle %0d", q_fstart.size(), tc + 1); end
        if (q_fstart.size() > 0 && q_fv.size() > 0) begin
            checks++; if (q_fv[0] - q_fstart[0] !== 7 * (10 + 1 + 2) + 1) begin errors++; $display("FAIL frame_latency: got %0d need %0d", q_fv[0] - q_fstart[0], 7 * 13 + 1); end
        end
        checks++; if (dut_regs() !== 56'h24_08_15_04_23_59_30) begin errors++; $display("FAIL frame_regs: got %0h need 24081504235930", dut_regs()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL frame_err: got %0b need 0", err); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL frame_rd_stable: got %0d changes need 0", stab_err); end
        checks++; if (dur[0] !== 11 || dur[6] !== 11) begin errors++; $display("FAIL frame_start_len: got %0d/%0d need 11", dur[0], dur[6]); end
    endtask

    task automatic test_random_frames();
        int tc, fv0, flen;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) begin
                lat[i] = int'($urandom_range(8, 1));
                dat[i] = 8'($urandom_range(255, 0));
            end
            hang_idx = -1;
            flen = frame_len();
            clear_logs();
            fv0 = fv_cnt;
            pulse_trig(tc);
            wait_idle(2000);
            exp_regs = pack_dat();
            checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL rand_regs[%0d]: got %0h need %0h", k, dut_regs(), exp_regs); end
            checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL rand_fvcount[%0d]: got %0d need 1", k, fv_cnt - fv0); end
            if (q_fstart.size() > 0 && q_fv.size() > 0) begin
                checks++; if (q_fv[0] - q_fstart[0] !== flen) begin errors++; $display("FAIL rand_latency[%0d]: got %0d need %0d", k, q_fv[0] - q_fstart[0], flen); end
            end else begin
                checks++; errors++; $display("FAIL rand_latency[%0d]: got no frame, need one", k);
            end
        end
    endtask

    task automatic test_timeout();
        int tc, fv0;
        logic [55:0] prior;
        prior = exp_regs;
        set_engine(5);
        hang_idx = 3;
        clear_logs();
        fv0 = fv_cnt;
        pulse_trig(tc);
        wait_idle(TOUT + 500);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b need 1", err); end
        checks++; if (dut_regs() !== prior) begin errors++; $display("FAIL to_regs_kept: got %0h need %0h", dut_regs(), prior); end
        checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL to_no_fv: got %0d need 0", fv_cnt - fv0); end
        checks++; if (dur[3] !== TOUT) begin errors++; $display("FAIL to_start_len: got %0d need %0d", dur[3], TOUT); end
        checks++; if (seq_ok(0, 4) != 1) begin errors++; $display("FAIL to_rdseq: got %0d addrs, need 0..3", q_rd.size()); end
        // Recovery with a healthy engine.
        set_engine(3);
        clear_logs();
        fv0 = fv_cnt;
        pulse_trig(tc);
        wait_idle(2000);
        exp_regs = pack_dat();
        checks++; if (seq_ok(0, 7) != 1) begin errors++; $display("FAIL to_rec_rdseq: got %0d addrs, need 0..6", q_rd.size()); end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL to_rec_regs: got %0h need %0h", dut_regs(), exp_regs); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_rec_err: got %0b need 0", err); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL to_rec_fv: got %0d need 1", fv_cnt - fv0); end
    endtask

    task automatic test_over_at_expiry();
        int tc, fv0;
        set_engine(2);
        lat[2] = TOUT - 1;   // over lands on the last watchdog cycle
        clear_logs();
        fv0 = fv_cnt;
        pulse_trig(tc);
        wait_idle(TOUT + 500);
        exp_regs = pack_dat();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL edge_err: got %0b need 0", err); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL edge_fv: got %0d need 1", fv_cnt - fv0); end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL edge_regs: got %0h need %0h", dut_regs(), exp_regs); end
        checks++; if (dur[2] !== TOUT) begin errors++; $display("FAIL edge_start_len: got %0d need %0d", dur[2], TOUT); end
    endtask

    task automatic test_back_to_back();
        int tc, fv0;
        set_engine(4);
        clear_logs();
        fv0 = fv_cnt;
        pulse_trig(tc);
        repeat (20) @(negedge clk);
        pulse_trig(tc);
        repeat (3) @(negedge clk);
        pulse_trig(tc);
        wait_idle(2000);
        exp_regs = pack_dat();
        checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL b2b_fvcount: got %0d need 2", fv_cnt - fv0); end
        checks++; if (seq_ok(0, 14) != 1) begin errors++; $display("FAIL b2b_rdseq: got %0d addrs, need 0..6 twice", q_rd.size()); end
        if (q_fstart.size() == 2 && q_fv.size() == 2) begin
            checks++; if (q_fstart[1] !== q_fv[0] + 1) begin errors++; $display("FAIL b2b_restart: got %0d need %0d", q_fstart[1], q_fv[0] + 1); end
        end else begin
            checks++; errors++; $display("FAIL b2b_frames: got %0d starts need 2", q_fstart.size());
        end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL b2b_regs: got %0h need %0h", dut_regs(), exp_regs); end
    endtask

    task automatic test_auto_poll();
        int tc, en_cyc, fv0, flen, n;
        int exp_st [3];
        set_engine(3);
        flen = frame_len();
        clear_logs();
        fv0 = fv_cnt;
        @(negedge clk);
        auto_en = 1'b1;
        en_cyc = cyc;
        n = 0;
        while (q_fstart.size() == 0 && n < 2 * PDIV) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        pulse_trig(tc);
        repeat (10) @(negedge clk);
        pulse_trig(tc);
        while (cyc < en_cyc + 2 * PDIV + flen + 20) @(negedge clk);
        auto_en = 1'b0;
        wait_idle(2000);
        exp_st[0] = en_cyc + PDIV;
        exp_st[1] = exp_st[0] + flen + 1;
        exp_st[2] = en_cyc + 2 * PDIV;
        exp_regs = pack_dat();
        checks++; if (q_fstart.size() !== 3) begin errors++; $display("FAIL auto_nframes: got %0d need 3", q_fstart.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < q_fstart.size()) begin
                checks++; if (q_fstart[i] !== exp_st[i]) begin errors++; $display("FAIL auto_start[%0d]: got %0d need %0d", i, q_fstart[i], exp_st[i]); end
            end
        end
        checks++; if (fv_cnt - fv0 !== 3) begin errors++; $display("FAIL auto_fvcount: got %0d need 3", fv_cnt - fv0); end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL auto_regs: got %0h need %0h", dut_regs(), exp_regs); end
        // Counter is held with auto_en low: nothing starts over a full period.
        clear_logs();
        repeat (PDIV + 20) @(negedge clk);
        checks++; if (q_fstart.size() !== 0) begin errors++; $display("FAIL auto_off: got %0d frames need 0", q_fstart.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int tc, fv0, n;
        set_engine(6);
        clear_logs();
        fv0 = fv_cnt;
        pulse_trig(tc);
        n = 0;
        while (!(bus.i2c_start && bus.i2c_rdaddr == 8'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.i2c_rdaddr !== 8'd4) begin errors++; $display("FAIL mrst_reach: got rdaddr %0h need 4", bus.i2c_rdaddr); end
        #2 rst = 1'b0;
        #1;
        exp_regs = '0;
        checks++; if (bus.i2c_start !== 1'b0) begin errors++; $display("FAIL mrst_start: got %0b need 0", bus.i2c_start); end
        checks++; if (bus.i2c_rdaddr !== 8'h00) begin errors++; $display("FAIL mrst_rdaddr: got %0h need 00", bus.i2c_rdaddr); end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL mrst_regs: got %0h need 0", dut_regs()); end
        checks++; if (busy !== 1'b0 || err !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL mrst_flags: got busy=%0b err=%0b fv=%0b need 0", busy, err, frame_valid); end
        checks++; if (bus.i2c_deviceaddw !== 8'hD0 || bus.i2c_deviceaddr !== 8'hD1) begin errors++; $display("FAIL mrst_addrs: got %0h/%0h need d0/d1", bus.i2c_deviceaddw, bus.i2c_deviceaddr); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL mrst_no_fv: got %0d need 0", fv_cnt - fv0); end
        set_engine(2);
        clear_logs();
        pulse_trig(tc);
        wait_idle(2000);
        exp_regs = pack_dat();
        checks++; if (seq_ok(0, 7) != 1) begin errors++; $display("FAIL mrst_rdseq: got %0d addrs, need 0..6", q_rd.size()); end
        checks++; if (dut_regs() !== exp_regs) begin errors++; $display("FAIL mrst_regs_after: got %0h need %0h", dut_regs(), exp_regs); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mrst_err_after: got %0b need 0", err); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random_frames();
        test_timeout();
        test_over_at_expiry();
        test_back_to_back();
        test_auto_poll();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: got no finish, need finish within 3ms");
        $fatal(1);
    end

endmodule

// File: doc/ds3231_poll_ctrl.md
DS3231_POLL_CTRL -- requirements
Module: ds3231_poll_ctrl

Interface
REQ-001 Parameter: DEV_ADDR, 7'h68, 7-bit I2C slave address of the RTC.
REQ-002 Parameter: POLL_DIV, 1000000, clk cycles between automatic poll frames.
REQ-003 Parameter: TIMEOUT, 4096, max clk cycles allowed per byte read before abort.
REQ-004 Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- auto_en  input  1  enables periodic polling.
- trig  input  1  single-cycle request for one poll frame.
- i2c_start  output  1  held high to run one byte-read transaction.
- i2c_deviceaddw  output  8  write address, constant {DEV_ADDR,1'b0}.
- i2c_deviceaddr  output  8  read address, constant {DEV_ADDR,1'b1}.
- i2c_rdaddr  output  8  RTC register index for the current byte.
- i2c_over  input  1  read engine done; level, stays high while i2c_start stays high.
- i2c_rddat  input  8  byte returned by the read engine, valid while i2c_over=1.
- sec, min, hour, day, date, month, year  output  8 each  committed RTC registers 0x00..0x06 (raw BCD).
- frame_valid  output  1  one-cycle pulse on commit of a new frame.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky timeout flag.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, GAP, COMMIT and ABORT.
REQ-006 The period counter SHALL run in every state while auto_en=1, wrap from POLL_DIV-1 to 0, produce a tick at POLL_DIV-1, and hold at 0 while auto_en=0.
REQ-007 The request pending flag SHALL set on trig=1 or on a tick and clear when IDLE leaves for ISSUE; multiple requests while busy SHALL coalesce into one.
REQ-008 IDLE -> ISSUE SHALL occur on the cycle after a request is seen (pending=1, or trig/tick in that same cycle); the byte index SHALL be 0 and the watchdog cleared.
REQ-009 In ISSUE, i2c_start=1 and i2c_rdaddr=index (0..6); the watchdog SHALL increment each cycle.
REQ-010 In ISSUE with i2c_over=1, i2c_rddat SHALL be stored into shadow[index] and the FSM SHALL go to GAP; over takes priority over a simultaneous watchdog expiry.
REQ-011 In ISSUE with the watchdog at TIMEOUT-1 and i2c_over=0, the FSM SHALL go to ABORT.
REQ-012 GAP SHALL last exactly 2 cycles with i2c_start=0, then:
- index=6 -> COMMIT;
- otherwise index+1 -> ISSUE, with the watchdog cleared.
REQ-013 COMMIT (1 cycle) SHALL copy shadow[0..6] to sec..year atomically, pulse frame_valid=1, clear err, and go to IDLE.
REQ-014 ABORT (1 cycle) SHALL set err=1, force i2c_start=0, discard the shadow, leave sec..year unchanged with no frame_valid, and go to IDLE; a pending request then starts a fresh frame from index 0.
REQ-015 i2c_start SHALL be a registered output, high only in ISSUE.
REQ-016 i2c_rdaddr SHALL change only outside ISSUE, i.e. stable for the whole transaction.
REQ-017 Frame latency with an engine taking N cycles from start to over:
- 7*(N+1+2) + 1 cycles from ISSUE entry to frame_valid.
REQ-018 trig while busy SHALL NOT restart the current frame.

Reset
REQ-019 While rst=0 the block SHALL be asynchronously forced to:
- state IDLE;
- i2c_start=0, i2c_rdaddr=8'h00;
- sec..year=8'h00, shadow=0;
- frame_valid=0, busy=0, err=0;
- pending=0, period counter=0, watchdog=0.
REQ-020 i2c_deviceaddw=8'hD0 and i2c_deviceaddr=8'hD1 (defaults) SHALL hold in and out of reset.
REQ-021 Reset asserted mid-frame SHALL drop i2c_start immediately, with no commit and no err.

Verification
REQ-022 trig pulse, engine model returns over 10 cycles after start with bytes 0x30,0x59,0x23,0x04,0x15,0x08,0x24 -> rdaddr sequence 0..6, sec=0x30 ... year=0x24, single frame_valid pulse, err=0.
REQ-023 Model never asserts over for byte 3 -> i2c_start drops after 4096 cycles, err=1, outputs keep prior frame values; the next trig with a good model -> commit and err=0.
REQ-024 POLL_DIV=200, auto_en=1, trig also pulsed mid-frame -> exactly one extra frame afterwards (coalesced), ticks spaced 200 cycles.
REQ-025 rst=0 asserted at byte 4 -> all outputs immediately at reset values; after release, a trig runs a full frame from rdaddr=0.
REQ-026 over and watchdog expiry in the same cycle -> byte captured, no abort.
